axi_read_responder: RTL
=======================

Name: axi_read_responder

Overview:
- Memory-side AXI read responder: the slave end of the axi_read_address / axi_read_data interfaces that i_cache and d_cache drive as masters.
- Holds a word-addressed backing store, preloaded through a backdoor write port, and accepts one burst request at a time.
- After a programmable latency it returns the requested burst as back-to-back R beats.
- Used as the memory model in cache testbenches and as the FPGA on-chip memory behind the caches.

Parameters:
- MEM_ADDR_WIDTH, 10, log2 of backing-store depth in 32-bit words.
- READ_LATENCY, 4, cycles from AR handshake to first RVALID; legal range 1..15.
- MAX_BURST, 16, maximum beats per burst; longer requests are clamped.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- mem_read_address  axi_read_address.slave  -  carries ARADDR[`ADDR_WIDTH], ARLEN, ARVALID and ARID[4] in; ARREADY out.
- mem_read_data  axi_read_data.slave  -  carries RREADY in; RDATA[`DATA_WIDTH], RVALID, RLAST and RID[4] out.
- i_bd_we  in  1  backdoor write enable.
- i_bd_waddr  in  MEM_ADDR_WIDTH  backdoor word address.
- i_bd_wdata  in  `DATA_WIDTH  backdoor write data.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, port rst.
- Reset values while rst is high and on the first cycle after release:
  - state = IDLE.
  - ARREADY = 0 while rst is high, 1 from the first cycle after release.
  - RVALID = 0, RLAST = 0, RDATA = 0, RID = 0.
  - Backing-store contents are not cleared.
- ARLEN convention: ARLEN is the beat count, as the caches drive it (LINE_SIZE).
  - ARLEN = 0 is treated as 1 beat.
  - ARLEN > MAX_BURST is clamped to MAX_BURST.
- Word address: ARADDR[MEM_ADDR_WIDTH+1:2]. ARADDR[1:0] is ignored, and upper bits beyond the store are ignored, so addresses alias modulo the depth.
- Beat addressing: incrementing burst, +1 word per beat. The word address wraps from 2^MEM_ADDR_WIDTH-1 to 0.
- Outstanding requests: exactly one. ARREADY = 1 only in IDLE. A pending ARVALID in any other state waits.
- States:
  - IDLE: on ARVALID & ARREADY, latch base address, beat count and ARID; go to LATENCY. The latency counter loads READ_LATENCY-1.
  - LATENCY: decrement the counter each cycle. At 0, go to BURST with the first beat's data valid. The first RVALID is asserted exactly READ_LATENCY cycles after the AR handshake edge; READ_LATENCY = 1 gives RVALID on the next cycle.
  - BURST: RVALID = 1. Each RVALID & RREADY advances the address and decrements the remaining-beat count.
    - RLAST = 1 only while the final beat is presented.
    - On the final-beat handshake, go to IDLE. ARREADY rises on the next cycle (one-cycle turnaround, no overlap).
- Stall rule: while RVALID & ~RREADY, RDATA, RLAST and RID hold stable. The next beat must be ready the cycle after each handshake, so sustained RREADY yields one beat per cycle with no bubbles.
- RID: equals the latched ARID for every beat of the burst.
- Storage: synchronous-read bank. Issue the read for beat n+1 on the handshake of beat n, so RDATA is sourced from a registered value.
- Backdoor writes:
  - Allowed in any state, one word per cycle.
  - A write to a word not yet fetched for the current burst is visible in that burst.
  - A write in the same cycle as the fetch of that word returns the old value.
- Reset mid-burst: everything returns to reset values immediately (asynchronously). The burst is abandoned and no RLAST is produced. The master must reissue the request.

Decomposition:
- Package axi_resp_pkg:
  - state enum {IDLE, LATENCY, BURST}.
  - MAX_BURST default.
  - beat-count width = $clog2(MAX_BURST+1).
- Sub-module: existing cache_bank as the backing store, DATA_WIDTH=`DATA_WIDTH, ADDR_WIDTH=MEM_ADDR_WIDTH.
  - Write port: backdoor.
  - Read port: next-fetch address.

Test Plan:
- Preload words 0x10..0x13 = A0..A3; ARADDR=0x40, ARLEN=4, ARID=3, READ_LATENCY=4, RREADY held 1 -> RVALID first at handshake+4; beats A0,A1,A2,A3 on consecutive cycles; RLAST on the 4th beat only; RID=3 on every beat; ARREADY back to 1 on the next cycle.
- Same burst with RREADY toggled 1,0,0,1,0,1,1 -> data sequence unchanged; RDATA/RLAST stable during every RVALID & ~RREADY cycle.
- ARADDR = last word of store (0xFFC with MEM_ADDR_WIDTH=10), ARLEN=2 -> beats mem[1023], mem[0].
- ARLEN=0 -> single beat with RLAST=1; ARLEN=20 -> exactly 16 beats, RLAST on the 16th.
- Second ARVALID asserted during BURST -> ARREADY stays 0 until one cycle after RLAST handshake; second burst then served correctly.
- Assert rst on the 2nd beat of a 4-beat burst -> RVALID drops at once; after release ARREADY=1; a new request returns correct data; preloaded memory is intact.

Source files
------------

// File: rtl/axi_resp_pkg.sv
// axi_resp_pkg: shared types, widths and burst-length helper for the read responder
package axi_resp_pkg;
  typedef enum logic [1:0] {IDLE, LATENCY, BURST} state_t;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int ID_WIDTH = 4;
  localparam int LEN_WIDTH = 8;
  localparam int DEF_MAX_BURST = 16;
  localparam int BEAT_W = $clog2(DEF_MAX_BURST + 1);
  function automatic int beats(input logic [LEN_WIDTH-1:0] len, input int max);
    return len == '0 ? 1 : int'(len) > max ? max : int'(len);
  endfunction
endpackage

// File: rtl/axi_read_address.sv
// axi_read_address: AR channel between a cache master and a memory slave
interface axi_read_address;
  import axi_resp_pkg::*;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [LEN_WIDTH-1:0] arlen;
  logic [ID_WIDTH-1:0] arid;
  logic arvalid;
  logic arready;
  modport master (output araddr, arlen, arid, arvalid, input arready);
  modport slave (input araddr, arlen, arid, arvalid, output arready);
endinterface

// File: rtl/axi_read_data.sv
// axi_read_data: R channel between a memory slave and a cache master
interface axi_read_data;
  import axi_resp_pkg::*;
  logic [DATA_WIDTH-1:0] rdata;
  logic [ID_WIDTH-1:0] rid;
  logic rvalid;
  logic rlast;
  logic rready;
  modport master (input rdata, rid, rvalid, rlast, output rready);
  modport slave (output rdata, rid, rvalid, rlast, input rready);
endinterface

// File: rtl/cache_bank.sv
// cache_bank: one-write one-read synchronous RAM, read returns pre-write contents
module cache_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input logic clk,
  input logic we,
  input logic [ADDR_WIDTH-1:0] waddr,
  input logic [DATA_WIDTH-1:0] wdata,
  input logic re,
  input logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  // write port and registered read port; no reset so contents survive rst
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/axi_read_responder.sv
// axi_read_responder: single-outstanding AXI read slave over a synchronous-read word store
module axi_read_responder
  import axi_resp_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int READ_LATENCY = 4,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input logic clk,
  input logic rst,
  axi_read_address.slave mem_read_address,
  axi_read_data.slave mem_read_data,
  input logic i_bd_we,
  input logic [MEM_ADDR_WIDTH-1:0] i_bd_waddr,
  input logic [DATA_WIDTH-1:0] i_bd_wdata
);
  localparam int CW = $clog2(MAX_BURST + 1);
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [MEM_ADDR_WIDTH-1:0] addr, addr_n;
  logic [CW-1:0] left, left_n;
  logic [ID_WIDTH-1:0] id, id_n;
  logic [DATA_WIDTH-1:0] q;
  logic re, last, ar_hs, unused_addr;
  assign unused_addr = ^{mem_read_address.araddr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2], mem_read_address.araddr[1:0]};
  assign mem_read_address.arready = state == IDLE && !rst;
  assign ar_hs = mem_read_address.arvalid && mem_read_address.arready;
  assign last = left == CW'(1);
  assign mem_read_data.rvalid = state == BURST;
  assign mem_read_data.rlast = state == BURST && last;
  assign mem_read_data.rdata = state == BURST ? q : '0;
  assign mem_read_data.rid = state == BURST ? id : '0;
  cache_bank #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(MEM_ADDR_WIDTH)) u_bank (
    .clk(clk),
    .we(i_bd_we),
    .waddr(i_bd_waddr),
    .wdata(i_bd_wdata),
    .re(re),
    .raddr(addr),
    .rdata(q)
  );
  // burst bookkeeping registers; addr always points at the next word to fetch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      addr <= '0;
      left <= '0;
      id <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      addr <= addr_n;
      left <= left_n;
      id <= id_n;
    end
  end
  // next state: prefetch first word as latency expires, then one word per accepted beat
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    addr_n = addr;
    left_n = left;
    id_n = id;
    re = 1'b0;
    case (state)
      IDLE: if (ar_hs) begin
        state_n = LATENCY;
        cnt_n = 4'(READ_LATENCY - 1);
        addr_n = mem_read_address.araddr[MEM_ADDR_WIDTH+1:2];
        left_n = CW'(beats(mem_read_address.arlen, MAX_BURST));
        id_n = mem_read_address.arid;
      end
      LATENCY: begin
        cnt_n = cnt - 4'd1;
        if (cnt == '0) begin
          state_n = BURST;
          re = 1'b1;
          addr_n = addr + 1'b1;
        end
      end
      BURST: if (mem_read_data.rready) begin
        left_n = left - CW'(1);
        state_n = last ? IDLE : BURST;
        re = !last;
        addr_n = last ? addr : addr + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
